// File: rtl/capture_pretrig.sv
// Pre-trigger capture buffer: samples stream into a circular RAM, and a programmable number
// of samples from before the trigger is kept alongside the post-trigger samples.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no capture; writes stopped
// FILL  | collecting the first pretrig samples; trigger ignored
// ARMED | pre-trigger window full; writes wrap until a trigger sample
// POST  | writing the remaining DEPTH - pretrig samples after the trigger
// DONE  | buffer frozen until the next arm
module capture_pretrig #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [DATAWIDTH-1:0] sample_data_in,
    input  logic                 sample_sot_in,
    input  logic                 sample_eot_in,
    input  logic                 sample_valid_in,
    input  logic                 arm,
    input  logic                 trig,
    input  logic                 trig_mode,
    input  logic [ADDRWIDTH-1:0] pretrig,
    output logic                 armed,
    output logic                 triggered,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] trig_addr,
    output logic [ADDRWIDTH-1:0] ram_wr_addr,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH+1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDRWIDTH;
    localparam int CW    = ADDRWIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [ADDRWIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [ADDRWIDTH-1:0] trig_addr_q, trig_addr_nxt;
    logic [ADDRWIDTH-1:0] pretrig_q, pretrig_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [CW-1:0]        post_len;
    logic                 we;
    logic                 trig_hit;

    logic [DATAWIDTH+1:0] mem [DEPTH];

    // Post-trigger length includes the trigger sample itself; it is DEPTH when pretrig is 0.
    assign post_len = CW'(DEPTH) - {1'b0, pretrig_q};
    assign trig_hit = sample_valid_in && trig && (!trig_mode || sample_sot_in);

    always_comb begin
        state_nxt     = state;
        wr_addr_nxt   = wr_addr;
        trig_addr_nxt = trig_addr_q;
        pretrig_nxt   = pretrig_q;
        cnt_nxt       = cnt;
        we            = 1'b0;
        if (arm) begin
            pretrig_nxt   = pretrig;
            wr_addr_nxt   = '0;
            trig_addr_nxt = '0;
            cnt_nxt       = {1'b0, pretrig};
            state_nxt     = (pretrig == '0) ? S_ARMED : S_FILL;
        end else begin
            case (state)
                S_FILL: begin
                    if (sample_valid_in) begin
                        we          = 1'b1;
                        wr_addr_nxt = wr_addr + 1'b1;
                        cnt_nxt     = cnt - 1'b1;
                        if (cnt == CW'(1)) state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_valid_in) begin
                        we          = 1'b1;
                        wr_addr_nxt = wr_addr + 1'b1;
                        if (trig_hit) begin
                            trig_addr_nxt = wr_addr;
                            cnt_nxt       = post_len - 1'b1;
                            state_nxt     = (post_len == CW'(1)) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_valid_in) begin
                        we          = 1'b1;
                        wr_addr_nxt = wr_addr + 1'b1;
                        cnt_nxt     = cnt - 1'b1;
                        if (cnt == CW'(1)) state_nxt = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state       <= S_IDLE;
            wr_addr     <= '0;
            trig_addr_q <= '0;
            pretrig_q   <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            wr_addr     <= wr_addr_nxt;
            trig_addr_q <= trig_addr_nxt;
            pretrig_q   <= pretrig_nxt;
            cnt         <= cnt_nxt;
        end
    end

    // RAM contents survive reset; the read is read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= {sample_eot_in, sample_sot_in, sample_data_in};
    end

    always_ff @(posedge clk) begin
        if (!reset_l) rd_data <= '0;
        else          rd_data <= mem[rd_addr];
    end

    assign armed       = (state == S_ARMED);
    assign triggered   = (state == S_POST) || (state == S_DONE);
    assign done        = (state == S_DONE);
    assign trig_addr   = trig_addr_q;
    assign ram_wr_addr = wr_addr;

endmodule

// File: tb/tb_capture_pretrig.sv
// Directed bench for capture_pretrig: stimulus queues expected status/readback values,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_capture_pretrig;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic [DW-1:0] sample_data_in = '0;
    logic          sample_sot_in = 1'b0;
    logic          sample_eot_in = 1'b0;
    logic          sample_valid_in = 1'b0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic          trig_mode = 1'b0;
    logic [AW-1:0] pretrig = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          armed, triggered, done;
    logic [AW-1:0] trig_addr, ram_wr_addr;
    logic [DW+1:0] rd_data;

    capture_pretrig #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .reset_l(reset_l),
        .sample_data_in(sample_data_in), .sample_sot_in(sample_sot_in),
        .sample_eot_in(sample_eot_in), .sample_valid_in(sample_valid_in),
        .arm(arm), .trig(trig), .trig_mode(trig_mode), .pretrig(pretrig),
        .armed(armed), .triggered(triggered), .done(done),
        .trig_addr(trig_addr), .ram_wr_addr(ram_wr_addr),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t st_q[$];
    logic rd_req = 1'b0;
    logic st_req = 1'b0;
    logic rd_vld_d = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // A read request issued before an edge has its data on rd_data after that edge.
    always @(posedge clk) rd_vld_d <= rd_req;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [12:0] st_act;
        if (st_req) begin
            n_checks++;
            st_act = {armed, triggered, done, trig_addr, ram_wr_addr};
            if (st_q.size() == 0) begin
                n_fail++;
                $display("FAIL status_unexpected: got %h with no expected entry", st_act);
            end else begin
                e = st_q.pop_front();
                if (st_act !== e.exp[12:0]) begin
                    n_fail++;
                    $display("FAIL %s: {armed,trig'd,done,trig_addr,wr_addr} got a=%b t=%b d=%b ta=%0d wa=%0d expected a=%b t=%b d=%b ta=%0d wa=%0d",
                             e.name, armed, triggered, done, trig_addr, ram_wr_addr,
                             e.exp[12], e.exp[11], e.exp[10], e.exp[9:5], e.exp[4:0]);
                end
            end
        end
        if (rd_vld_d) begin
            n_checks++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_data=%h with no expected entry", rd_data);
            end else begin
                e = rd_q.pop_front();
                if (rd_data !== e.exp[DW+1:0]) begin
                    n_fail++;
                    $display("FAIL %s: rd_data got %h expected %h", e.name, rd_data, e.exp[DW+1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input string name, input logic a, input logic t, input logic d,
                           input logic [AW-1:0] ta, input logic [AW-1:0] wa);
        exp_t e;
        e.name = name;
        e.exp  = 16'({a, t, d, ta, wa});
        st_q.push_back(e);
        st_req = 1'b1;
    endtask

    task automatic push_rd(input string name, input logic [AW-1:0] addr, input logic [DW+1:0] exp);
        exp_t e;
        e.name  = name;
        e.exp   = 16'(exp);
        rd_addr = addr;
        rd_q.push_back(e);
        rd_req  = 1'b1;
    endtask

    task automatic check_status(input string name, input logic a, input logic t, input logic d,
                                input logic [AW-1:0] ta, input logic [AW-1:0] wa);
        push_st(name, a, t, d, ta, wa);
        tick();
        st_req = 1'b0;
    endtask

    task automatic read(input string name, input logic [AW-1:0] addr, input logic [DW+1:0] exp);
        push_rd(name, addr, exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic samp(input logic [DW-1:0] d, input logic v = 1'b1,
                        input logic s = 1'b0, input logic e = 1'b0);
        sample_data_in  = d;
        sample_valid_in = v;
        sample_sot_in   = s;
        sample_eot_in   = e;
        tick();
        sample_valid_in = 1'b0;
        sample_sot_in   = 1'b0;
        sample_eot_in   = 1'b0;
    endtask

    task automatic do_arm(input logic [AW-1:0] p);
        pretrig = p;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int budget;
        // Reset: outputs and rd_data cleared.
        reset_l = 1'b0;
        tick();
        push_st("reset_status", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        push_rd("reset_rd_data", 5'd0, 10'd0);
        tick();
        st_req = 1'b0;
        rd_req = 1'b0;
        reset_l = 1'b1;
        tick();

        // Scenario 1: pretrig 0, trigger on sample 10.
        trig_mode = 1'b0;
        do_arm(5'd0);
        check_status("s1_armed_at_arm", 1, 0, 0, 5'd0, 5'd0);
        for (int i = 0; i < 42; i++) begin
            trig = (i == 10);
            samp(8'(i));
            if (i == 9)  check_status("s1_pre_trig", 1, 0, 0, 5'd0, 5'd10);
            if (i == 10) check_status("s1_trig", 0, 1, 0, 5'd10, 5'd11);
            if (i == 40) check_status("s1_not_done", 0, 1, 0, 5'd10, 5'd9);
        end
        trig = 1'b0;
        check_status("s1_done", 0, 1, 1, 5'd10, 5'd10);
        trig = 1'b1;
        samp(8'd42);
        trig = 1'b0;
        check_status("s1_done_holds", 0, 1, 1, 5'd10, 5'd10);
        read("s1_rd10", 5'd10, 10'd10);
        read("s1_rd9", 5'd9, 10'd41);
        read("s1_rd0_wrapped", 5'd0, 10'd32);

        // Scenario 2: pretrig 4, trigger on sample 20.
        do_arm(5'd4);
        for (int i = 0; i < 48; i++) begin
            trig = (i == 20);
            samp(8'(i));
            if (i == 2)  check_status("s2_fill", 0, 0, 0, 5'd0, 5'd3);
            if (i == 3)  check_status("s2_armed", 1, 0, 0, 5'd0, 5'd4);
            if (i == 20) check_status("s2_trig", 0, 1, 0, 5'd20, 5'd21);
            if (i == 46) check_status("s2_not_done", 0, 1, 0, 5'd20, 5'd15);
        end
        trig = 1'b0;
        check_status("s2_done", 0, 1, 1, 5'd20, 5'd16);
        read("s2_rd16_oldest", 5'd16, 10'd16);
        read("s2_rd15_newest", 5'd15, 10'd47);
        read("s2_rd20_trig", 5'd20, 10'd20);

        // Scenario 3: trig held high from arm; FILL ignores it.
        trig = 1'b1;
        do_arm(5'd8);
        for (int i = 0; i < 32; i++) begin
            samp(8'(i));
            if (i == 7) check_status("s3_armed", 1, 0, 0, 5'd0, 5'd8);
            if (i == 8) check_status("s3_trig", 0, 1, 0, 5'd8, 5'd9);
        end
        check_status("s3_done", 0, 1, 1, 5'd8, 5'd0);
        trig = 1'b0;

        // Arm on the same cycle as a trigger sample restarts and drops that sample.
        do_arm(5'd0);
        for (int i = 0; i < 5; i++) samp(8'(100 + i));
        pretrig = 5'd0;
        arm = 1'b1;
        trig = 1'b1;
        samp(8'hAA);
        arm = 1'b0;
        trig = 1'b0;
        check_status("arm_beats_trig", 1, 0, 0, 5'd0, 5'd0);
        read("arm_beats_trig_rd0", 5'd0, 10'd100);

        // Scenario 4: trig_mode 1, sot only on sample 13; includes a same-address read.
        trig_mode = 1'b1;
        trig = 1'b1;
        do_arm(5'd2);
        for (int i = 0; i < 43; i++) begin
            if (i == 20) push_rd("s4_rd_during_wr", 5'd20, 10'd20);
            samp(8'(i + 64), 1'b1, (i == 13), (i % 3 == 0));
            rd_req = 1'b0;
            if (i == 12) check_status("s4_wait_sot", 1, 0, 0, 5'd0, 5'd13);
            if (i == 13) check_status("s4_trig", 0, 1, 0, 5'd13, 5'd14);
            if (i == 41) check_status("s4_not_done", 0, 1, 0, 5'd13, 5'd10);
        end
        trig = 1'b0;
        trig_mode = 1'b0;
        check_status("s4_done", 0, 1, 1, 5'd13, 5'd11);
        read("s4_rd13_sot", 5'd13, {1'b0, 1'b1, 8'd77});
        read("s4_rd12_eot", 5'd12, {1'b1, 1'b0, 8'd76});
        read("s4_rd20_new", 5'd20, {1'b0, 1'b0, 8'd84});

        // Scenario 5: valid every other cycle.
        do_arm(5'd0);
        for (int k = 0; k < 10; k++) begin
            samp(8'(8'hC0 + k), (k % 2 == 0));
            if (k == 1) check_status("s5_invalid_skip", 1, 0, 0, 5'd0, 5'd1);
        end
        check_status("s5_wr_addr", 1, 0, 0, 5'd0, 5'd5);
        for (int j = 0; j < 5; j++) read("s5_rd_valid_only", 5'(j), 10'(8'hC0 + 2 * j));
        read("s5_rd5_untouched", 5'd5, 10'd101);

        // Scenario 6: reset during POST, then a fresh capture.
        do_arm(5'd2);
        for (int i = 0; i < 8; i++) begin
            trig = (i == 5);
            samp(8'(i));
        end
        trig = 1'b0;
        check_status("s6_post", 0, 1, 0, 5'd5, 5'd8);
        reset_l = 1'b0;
        tick();
        push_st("s6_rst_status", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        push_rd("s6_rst_rd_data", 5'd5, 10'd0);
        tick();
        st_req = 1'b0;
        rd_req = 1'b0;
        reset_l = 1'b1;
        read("s6_ram_kept", 5'd5, 10'd5);
        check_status("s6_idle", 0, 0, 0, 5'd0, 5'd0);
        trig = 1'b1;
        samp(8'h99);
        samp(8'h9A);
        trig = 1'b0;
        check_status("s6_idle_ignores", 0, 0, 0, 5'd0, 5'd0);
        do_arm(5'd2);
        for (int i = 0; i < 40; i++) begin
            trig = (i == 10);
            samp(8'(8'h50 + i));
            if (i == 38) check_status("s6_not_done", 0, 1, 0, 5'd10, 5'd7);
        end
        trig = 1'b0;
        check_status("s6_done", 0, 1, 1, 5'd10, 5'd8);
        read("s6_rd8_oldest", 5'd8, 10'h058);
        read("s6_rd7_newest", 5'd7, 10'h077);

        // Largest pretrig: the trigger sample alone is the post window.
        do_arm(5'd31);
        for (int i = 0; i < 31; i++) samp(8'(i));
        check_status("s7_armed", 1, 0, 0, 5'd0, 5'd31);
        trig = 1'b1;
        samp(8'd31);
        trig = 1'b0;
        check_status("s7_done", 0, 1, 1, 5'd31, 5'd0);

        budget = 0;
        while ((rd_q.size() != 0 || st_q.size() != 0) && budget < 20) begin
            tick();
            budget++;
        end
        n_checks++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads and %0d status checks left, expected 0",
                     rd_q.size(), st_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_pretrig.md
CAPTURE_PRETRIG -- requirements
Module: capture_pretrig

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of captured sample data.
REQ-002 Parameter ADDRWIDTH, default 5, buffer address width; DEPTH = 2**ADDRWIDTH entries.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_l  input  1  reset, synchronous, active-low.
REQ-005 sample_data_in  input  DATAWIDTH  sample data.
REQ-006 sample_sot_in  input  1  start-of-transfer marker, stored with sample.
REQ-007 sample_eot_in  input  1  end-of-transfer marker, stored with sample.
REQ-008 sample_valid_in  input  1  sample qualifier; only valid samples are stored or counted.
REQ-009 arm  input  1  one-cycle pulse; starts a new capture.
REQ-010 trig  input  1  trigger request, level.
REQ-011 trig_mode  input  1  0 = trig alone; 1 = trig AND sample_sot_in.
REQ-012 pretrig  input  ADDRWIDTH  number of samples kept before the trigger sample; sampled on arm.
REQ-013 armed  output  1  high in ARMED state.
REQ-014 triggered  output  1  high in POST and DONE states.
REQ-015 done  output  1  high in DONE state.
REQ-016 trig_addr  output  ADDRWIDTH  buffer address of the trigger sample.
REQ-017 ram_wr_addr  output  ADDRWIDTH  next buffer write address.
REQ-018 rd_addr  input  ADDRWIDTH  readback address.
REQ-019 rd_data  output  DATAWIDTH+2  {eot, sot, data} at rd_addr, registered.

Function
REQ-020 Buffer SHALL be a DEPTH x (DATAWIDTH+2) dual-port RAM: one write port, one read port.
REQ-021 FSM states SHALL be IDLE, FILL, ARMED, POST, DONE.
REQ-022 arm in any state SHALL latch pretrig, clear ram_wr_addr, trig_addr and the sample counter, then go to FILL, or to ARMED when pretrig = 0.
REQ-023 In FILL, ARMED and POST, each valid sample SHALL be written at ram_wr_addr; ram_wr_addr then increments mod DEPTH.
REQ-024 FILL SHALL count valid samples and go to ARMED on the cycle the pretrig-th sample is written.
REQ-025 trig SHALL be ignored in IDLE, FILL and DONE.
REQ-026 In ARMED, a valid sample meeting the trig_mode condition SHALL be written, set trig_addr to its address, and go to POST.
REQ-027 POST SHALL end after DEPTH - pretrig samples, trigger sample included, have been written; the FSM then goes to DONE.
REQ-028 With pretrig = 0, the trigger sample SHALL be the first of DEPTH post samples, and the whole buffer is post-trigger.
REQ-029 Writes SHALL stop in IDLE and DONE; the buffer holds its contents until the next arm.
REQ-030 Invalid cycles (sample_valid_in = 0) SHALL neither write nor advance ram_wr_addr or any counter.
REQ-031 Oldest sample after DONE SHALL be at trig_addr - pretrig mod DEPTH; newest at trig_addr - pretrig - 1 mod DEPTH.
REQ-032 rd_data SHALL be valid one clock after rd_addr, in every state.
REQ-033 A read of the address being written in the same cycle SHALL return the old contents.
REQ-034 arm on the same cycle as a trigger sample SHALL take priority: capture restarts and the trigger is discarded.
REQ-035 ARMED SHALL wait for a trigger with no timeout; buffer wrap in ARMED is legal and overwrites older samples continuously.

Reset
REQ-036 While reset_l is low at a clock edge, the FSM SHALL go to IDLE.
REQ-037 Reset SHALL drive armed, triggered, done, trig_addr, ram_wr_addr and rd_data to 0.
REQ-038 Reset SHALL NOT clear RAM contents.
REQ-039 Reset asserted mid-capture SHALL abort the capture; done does not assert until a new arm completes.

Verification (DATAWIDTH=8, ADDRWIDTH=5)
REQ-040 Scenario 1: pretrig=0, arm, valid ramp 0,1,2,..., trig on sample 10 -> armed=1 from first cycle; trig_addr=10; done after sample 41; rd_addr 10 -> data 10; rd_addr 9 -> data 41.
REQ-041 Scenario 2: pretrig=4, arm, ramp from 0, trig on sample 20 -> armed rises after sample 3; trig_addr=20; done after sample 47; rd_addr 16 -> 16, rd_addr 15 -> 47.
REQ-042 Scenario 3: pretrig=8, trig held high from arm -> no trigger during FILL; trigger sample is sample 8; trig_addr=8.
REQ-043 Scenario 4: trig_mode=1, trig high, sot on sample 13 only -> trig_addr=13; stored sot bit at addr 13 = 1, eot as driven.
REQ-044 Scenario 5: sample_valid_in toggled every other cycle -> ram_wr_addr advances only on valid cycles; buffer holds only valid samples, in order.
REQ-045 Scenario 6: reset_l low for 2 cycles during POST, then re-arm with pretrig=2 -> all outputs 0 during reset; done stays 0 until the new capture completes with correct trig_addr.
